ir_sram_console: RTL and testbench

- Parametrised keypad-driven SRAM access controller.
- Decoded IR remote key codes build a data entry word and an SRAM address, then execute a timed single read or write on an asynchronous SRAM.
- Sits between the IR receiver decoder and the board SRAM pins. Exposes entry, address and read-back registers for the 7-segment and LED display logic.
- Generalises the single-cycle console to any data or address width, with programmable access wait states, address stepping and an error flag.

---
 rtl/ir_sram_console_if.sv | 26 ++
 rtl/ir_sram_console.sv | 114 +++++++++++
 tb/tb_ir_sram_console.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ir_sram_console_if.sv
// ir_sram_console_if: keypad input and asynchronous SRAM pin bundle for ir_sram_console.
interface ir_sram_console_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int KEY_W  = 8
);
  logic              key_valid;
  logic [KEY_W-1:0]  key_code;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_o;
  logic [DATA_W-1:0] sram_dq_i;
  logic              sram_dq_oe;
  logic              sram_ce_n;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic              sram_lb_n;
  logic              sram_ub_n;
  modport master (
    output key_valid, key_code, sram_dq_i,
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n
  );
  modport slave (
    input  key_valid, key_code, sram_dq_i,
    output sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n
  );
endinterface

// File: rtl/ir_sram_console.sv
// ir_sram_console: IR keypad driven single-word read/write controller for an asynchronous SRAM.
// Define IR_SRAM_AUTOINC_EN to step addr after every completed access.
module ir_sram_console #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1,
  parameter int KEY_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ir_sram_console_if.slave  bus,
  output logic [DATA_W-1:0] entry,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              mode,
  output logic              busy,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_WAIT, R_END} state_t;
  localparam logic [KEY_W-1:0] K_DIG9 = KEY_W'('h09);
  localparam logic [KEY_W-1:0] K_LDA  = KEY_W'('h0F);
  localparam logic [KEY_W-1:0] K_CLR  = KEY_W'('h10);
  localparam logic [KEY_W-1:0] K_MODE = KEY_W'('h11);
  localparam logic [KEY_W-1:0] K_CLRA = KEY_W'('h13);
  localparam logic [KEY_W-1:0] K_GO   = KEY_W'('h17);
  localparam logic [KEY_W-1:0] K_INC  = KEY_W'('h1A);
  localparam logic [KEY_W-1:0] K_DEC  = KEY_W'('h1B);
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W+ADDR_W-1:0] entry_ext;
  logic idle_key, last;
  assign idle_key = bus.key_valid && state == IDLE;
  assign last = cnt == 4'd0;
  assign entry_ext = {{ADDR_W{1'b0}}, entry};
  assign bus.sram_addr = addr;
  assign bus.sram_dq_o = wdata;
  assign bus.sram_lb_n = 1'b0;
  assign bus.sram_ub_n = 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // Strobes decode straight from the state register so reset releases them immediately.
  always_comb begin
    state_nxt = state;
    busy = 1'b1;
    bus.sram_ce_n = 1'b0;
    bus.sram_we_n = 1'b1;
    bus.sram_oe_n = 1'b1;
    bus.sram_dq_oe = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        bus.sram_ce_n = 1'b1;
        if (idle_key && bus.key_code == K_GO) state_nxt = mode ? R_SETUP : W_SETUP;
      end
      W_SETUP: begin
        bus.sram_dq_oe = 1'b1;
        state_nxt = W_PULSE;
      end
      W_PULSE: begin
        bus.sram_dq_oe = 1'b1;
        bus.sram_we_n = 1'b0;
        if (last) state_nxt = W_HOLD;
      end
      W_HOLD: begin
        bus.sram_dq_oe = 1'b1;
        state_nxt = IDLE;
      end
      R_SETUP: begin
        bus.sram_oe_n = 1'b0;
        state_nxt = R_WAIT;
      end
      R_WAIT: begin
        bus.sram_oe_n = 1'b0;
        if (last) state_nxt = R_END;
      end
      R_END: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= 4'd0;
    else if (state == W_SETUP || state == R_SETUP) cnt <= 4'(WAIT_CYCLES - 1);
    else if ((state == W_PULSE || state == R_WAIT) && !last) cnt <= cnt - 4'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      entry <= '0;
      addr <= '0;
      rd_data <= '0;
      mode <= 1'b0;
      err <= 1'b0;
      wdata <= '0;
    end else begin
      if (idle_key) begin
        err <= 1'b0;
        if (bus.key_code <= K_DIG9) entry <= {entry[DATA_W-5:0], bus.key_code[3:0]};
        case (bus.key_code)
          K_CLR:  entry <= '0;
          K_LDA:  addr <= entry_ext[ADDR_W-1:0];
          K_CLRA: addr <= '0;
          K_MODE: mode <= ~mode;
          K_INC:  addr <= addr + 1'b1;
          K_DEC:  addr <= addr - 1'b1;
          K_GO:   wdata <= entry;
          default: ;
        endcase
      end else if (bus.key_valid) err <= 1'b1;
      if (state == R_WAIT && last) rd_data <= bus.sram_dq_i;
`ifdef IR_SRAM_AUTOINC_EN
      if (state == W_HOLD || state == R_END) addr <= addr + 1'b1;
`endif
    end
endmodule

// File: tb/tb_ir_sram_console.sv
// tb_ir_sram_console: directed plus randomized key stimulus against a behavioural console/SRAM model.
module tb_ir_sram_console;
  localparam int DW = 16, AW = 20, WC = 2, KW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ir_sram_console_if #(.DATA_W(DW), .ADDR_W(AW), .KEY_W(KW)) bus ();
  logic [DW-1:0] entry, rd_data;
  logic [AW-1:0] addr;
  logic mode, busy, err;
  ir_sram_console #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC), .KEY_W(KW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .entry(entry), .addr(addr),
    .rd_data(rd_data), .mode(mode), .busy(busy), .err(err)
  );
  int checks = 0, errors = 0;
  logic [DW-1:0] m_entry, m_rd, m_wdata;
  logic [AW-1:0] m_addr;
  logic m_mode, m_err;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] sram [logic [AW-1:0]];
  int ce_cnt, we_cnt, oe_cnt, dqoe_cnt, dq_bad, inv_bad;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    if (!bus.sram_ce_n) ce_cnt++;
    if (!bus.sram_we_n) we_cnt++;
    if (!bus.sram_oe_n) oe_cnt++;
    if (bus.sram_dq_oe) dqoe_cnt++;
    if (bus.sram_dq_oe && bus.sram_dq_o !== m_wdata) dq_bad++;
    if ((!bus.sram_we_n && !bus.sram_oe_n) || (bus.sram_dq_oe && !bus.sram_oe_n)) inv_bad++;
    if (!bus.sram_ce_n && !bus.sram_we_n) sram[bus.sram_addr] = bus.sram_dq_o;
    bus.sram_dq_i = sram.exists(bus.sram_addr) ? sram[bus.sram_addr] : 16'hDEAD;
  endtask
  task automatic model_reset();
    m_entry = '0; m_addr = '0; m_rd = '0; m_mode = 1'b0; m_err = 1'b0; m_wdata = '0;
  endtask
  task automatic check_regs(input string tag);
    chk({tag, ".entry"}, 32'(entry), 32'(m_entry));
    chk({tag, ".addr"}, 32'(addr), 32'(m_addr));
    chk({tag, ".mode"}, 32'(mode), 32'(m_mode));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
  endtask
  task automatic press(input logic [7:0] k);
    bus.key_valid = 1'b1;
    bus.key_code = k;
    cyc();
    bus.key_valid = 1'b0;
    m_err = 1'b0;
    if (k <= 8'h09) m_entry = m_entry * 16 + DW'(k);
    else if (k == 8'h10) m_entry = '0;
    else if (k == 8'h0F) m_addr = AW'(m_entry);
    else if (k == 8'h13) m_addr = '0;
    else if (k == 8'h11) m_mode = !m_mode;
    else if (k == 8'h1A) m_addr = m_addr + 1;
    else if (k == 8'h1B) m_addr = m_addr - 1;
    check_regs($sformatf("key%02h", k));
  endtask
  task automatic access(input bit inject);
    logic [AW-1:0] a;
    int n;
    a = m_addr;
    m_err = 1'b0;
    m_wdata = m_entry;
    ce_cnt = 0; we_cnt = 0; oe_cnt = 0; dqoe_cnt = 0; dq_bad = 0;
    bus.key_valid = 1'b1;
    bus.key_code = 8'h17;
    cyc();
    bus.key_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      if (inject && n == 1) begin
        bus.key_valid = 1'b1;
        bus.key_code = 8'($urandom_range(0, 9));
        m_err = 1'b1;
      end
      cyc();
      bus.key_valid = 1'b0;
      n++;
    end
    chk("acc.done", 32'(n < 20), 32'd1);
    if (!m_mode) ref_mem[a] = m_wdata;
    else m_rd = ref_mem.exists(a) ? ref_mem[a] : 16'hDEAD;
`ifdef IR_SRAM_AUTOINC_EN
    m_addr = m_addr + 1;
`endif
    chk("acc.ce_cycles", 32'(ce_cnt), 32'(WC + 2));
    chk("acc.we_cycles", 32'(we_cnt), m_mode ? 32'd0 : 32'(WC));
    chk("acc.oe_cycles", 32'(oe_cnt), m_mode ? 32'(WC + 1) : 32'd0);
    chk("acc.dqoe_cycles", 32'(dqoe_cnt), m_mode ? 32'd0 : 32'(WC + 2));
    chk("acc.dq_value", 32'(dq_bad), 32'd0);
    chk("acc.rd_data", 32'(rd_data), 32'(m_rd));
    if (!m_mode) chk("acc.sram_word", 32'(sram[a]), 32'(m_wdata));
    check_regs("acc");
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "simulation bound exceeded");
  end
  initial begin
    logic [7:0] keys [16];
    logic [7:0] k;
    keys = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h07, 8'h09, 8'h0F, 8'h10,
             8'h11, 8'h13, 8'h1A, 8'h1B, 8'h17, 8'h17, 8'h42, 8'h0C};
    bus.key_valid = 1'b0;
    bus.key_code = '0;
    bus.sram_dq_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    chk("reset.rd_data", 32'(rd_data), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.strobes", {29'd0, bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n}, 32'd7);
    chk("reset.dq_oe", 32'(bus.sram_dq_oe), 32'd0);
    chk("reset.dq_o", 32'(bus.sram_dq_o), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    press(8'h01); press(8'h02); press(8'h03); press(8'h04);
    chk("entry_1234", 32'(entry), 32'h1234);
    press(8'h0F);
    chk("addr_01234", 32'(addr), 32'h01234);
    access(1'b0);
    chk("write_ce", 32'(ce_cnt), 32'd4);
    chk("write_we", 32'(we_cnt), 32'd2);
`ifndef IR_SRAM_AUTOINC_EN
    press(8'h11);
    chk("mode_read", 32'(mode), 32'd1);
    access(1'b0);
    chk("read_back", 32'(rd_data), 32'h1234);
    chk("read_oe", 32'(oe_cnt), 32'd3);
`else
    press(8'h11);
`endif
    press(8'h13);
    press(8'h1B);
    chk("addr_wrap_dn", 32'(addr), 32'hFFFFF);
    press(8'h1A);
    chk("addr_wrap_up", 32'(addr), 32'h00000);
    press(8'h09); press(8'h08); press(8'h07); press(8'h06); press(8'h05);
    chk("entry_8765", 32'(entry), 32'h8765);
    press(8'h10);
    chk("entry_clr", 32'(entry), 32'h0);
    if (m_mode) press(8'h11);
    access(1'b1);
    chk("err_set", 32'(err), 32'd1);
    press(8'h42);
    chk("err_clr", 32'(err), 32'd0);
    for (int i = 0; i < 200; i++) begin
      k = keys[$urandom_range(0, 15)];
      if (k == 8'h17) access($urandom_range(0, 3) == 0);
      else press(k);
    end
    if (!m_mode) press(8'h11);
    bus.key_valid = 1'b1;
    bus.key_code = 8'h17;
    cyc();
    bus.key_valid = 1'b0;
    cyc();
    chk("abort.busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.ce_oe", {30'd0, bus.sram_ce_n, bus.sram_oe_n}, 32'd3);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.rd_data", 32'(rd_data), 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    cyc();
    check_regs("after_abort");
`ifdef IR_SRAM_AUTOINC_EN
    press(8'h01); press(8'h00); press(8'h0F);
    access(1'b0);
    access(1'b0);
    chk("autoinc.w0", 32'(sram[20'h00010]), 32'h0010);
    chk("autoinc.w1", 32'(sram[20'h00011]), 32'h0010);
    chk("autoinc.addr", 32'(addr), 32'h00012);
`endif
    chk("strobe_invariants", 32'(inv_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
